period_channel_scheduler: RTL
=============================

Name: period_channel_scheduler

Overview:
- Collects measurements from CHANNELS period-measure instances (e.g. pitch and volume antennas) and merges them into one valid/ready stream tagged with a channel index.
- Drives per-channel CE and discards each channel's warm-up samples after reset. The first period after reset is only one half-period, because the previous half-period starts at 0.
- Reports a channel as silent (timeout) when no measurement arrives for TIMEOUT_CYCLES.
- Sits in the CLK_PARALLEL domain between the sensor front-ends and the register/DSP consumer.

Parameters:
- CHANNELS, 2, number of period-measure channels (1..8).
- PERIOD_BITS, 16, width of each period value.
- DISCARD_COUNT, 2, samples dropped per channel after reset or after CE rises (0..3).
- TIMEOUT_BITS, 16, width of the per-channel silence counter.
- TIMEOUT_CYCLES, 65535, silence length in cycles that triggers a timeout report; must be less than 2^TIMEOUT_BITS.

Ports:
- CLK_PARALLEL  in  1  single clock; the block uses only this clock.
- RESET  in  1  reset, synchronous to CLK_PARALLEL, active-high.
- CE  in  1  global enable.
- CH_CE  out  CHANNELS  enable to each measure instance.
- CH_CHANGE_FLAG  in  CHANNELS  one-cycle new-value strobe per channel.
- CH_PERIOD  in  CHANNELS*PERIOD_BITS  channel i occupies bits [i*PERIOD_BITS +: PERIOD_BITS].
- OUT_VALID  out  1  output word valid.
- OUT_READY  in  1  consumer accepts.
- OUT_CHANNEL  out  max(1,$clog2(CHANNELS))  source channel index.
- OUT_PERIOD  out  PERIOD_BITS  measured period; 0 when OUT_TIMEOUT=1.
- OUT_TIMEOUT  out  1  word is a silence report.
- OVERRUN  out  CHANNELS  sticky flag: an unconsumed slot was overwritten.
- OVERRUN_CLEAR  in  1  clears all OVERRUN bits.

Behaviour:
- Reset:
  - OUT_VALID=0, OUT_CHANNEL=0, OUT_PERIOD=0, OUT_TIMEOUT=0, OVERRUN=0, CH_CE=0.
  - All slots empty, discard counters = DISCARD_COUNT, silence counters = 0, round-robin pointer = 0.
- CH_CE: registered copy of {CHANNELS{CE}}, so it follows CE with 1 cycle delay. Each rising edge of CE reloads every discard counter to DISCARD_COUNT.
- Capture, per channel, when CH_CE[i]=1 and CH_CHANGE_FLAG[i]=1:
  - If discard counter > 0: decrement it. No slot write. Silence counter reset to 0.
  - Otherwise: slot value = CH_PERIOD slice, slot timeout = 0, slot pending = 1, silence counter = 0.
  - If the slot was already pending and is not being granted this cycle: set OVERRUN[i]. The slot is overwritten with the newest value.
- Silence counter:
  - Increments while CH_CE[i]=1, the discard counter is 0, and no strobe arrives.
  - On reaching TIMEOUT_CYCLES it loads the slot with period 0, timeout 1, pending 1. OVERRUN follows the same rule as a capture.
  - It then saturates, giving one timeout report per silent interval. The next strobe re-arms it.
- While CH_CE[i]=0: captures are ignored and the silence counter holds. Pending slots keep draining.
- Arbiter:
  - Output register state: EMPTY or FULL.
  - A grant happens when EMPTY, or when FULL with OUT_READY=1.
  - On a grant, pick the first pending slot searching from (last granted + 1) mod CHANNELS. Load it into the output register, clear its pending bit, and update the pointer.
  - If nothing is pending: FULL with OUT_READY goes to EMPTY, OUT_VALID=0.
- Output stability: while OUT_VALID=1 and OUT_READY=0, OUT_VALID, OUT_CHANNEL, OUT_PERIOD and OUT_TIMEOUT hold unchanged.
- Latency: strobe at cycle t → slot pending at t+1 → OUT_VALID=1 at t+2, provided the output is EMPTY and the channel wins arbitration.
- Throughput: one word per cycle under OUT_READY=1.
- Same-cycle grant and capture on one channel: the output takes the old slot value, the slot stays pending with the new value, and OVERRUN is not set.
- OVERRUN_CLEAR and a new overrun in the same cycle: the bit ends set (set wins).
- RESET mid-transfer: takes effect in the next cycle. The output word is dropped and all state reinitialises.

Test Plan:
- Warm-up discard: reset, CE=1, ch0 strobes with periods 100, 2000, 2010 → only 2010 is output, with OUT_CHANNEL=0 and OUT_TIMEOUT=0. The 100 and 2000 are discarded.
- Latency: after warm-up, ch1 strobe 3000 at cycle t with OUT_READY=1 → OUT_VALID=1 at t+2 with OUT_CHANNEL=1 and OUT_PERIOD=3000.
- Round-robin: both channels pending every cycle, OUT_READY=1 → OUT_CHANNEL alternates 0,1,0,1. Neither channel starves.
- Backpressure and overrun: OUT_READY=0, ch0 gives two post-warm-up strobes → output holds the first value, slot keeps the second, OVERRUN[0]=1. OVERRUN_CLEAR then clears it.
- Timeout: TIMEOUT_CYCLES=50, ch1 silent after warm-up → exactly one word with OUT_CHANNEL=1, OUT_PERIOD=0, OUT_TIMEOUT=1, issued 50 cycles after the last strobe. No repeat until the next strobe.
- CE toggle: drop CE for 10 cycles, then raise it → CH_CE follows with 1 cycle delay, the silence counter held during the gap, and the next 2 strobes per channel are discarded.

Source files
------------

// File: rtl/period_channel_scheduler.sv
// period_channel_scheduler: merges per-channel period measurements into one channel-tagged valid/ready stream
module period_channel_scheduler #(
    parameter int CHANNELS       = 2,
    parameter int PERIOD_BITS    = 16,
    parameter int DISCARD_COUNT  = 2,
    parameter int TIMEOUT_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            CLK_PARALLEL,
    input  logic                            RESET,
    input  logic                            CE,
    output logic [CHANNELS-1:0]             CH_CE,
    input  logic [CHANNELS-1:0]             CH_CHANGE_FLAG,
    input  logic [CHANNELS*PERIOD_BITS-1:0] CH_PERIOD,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [CW-1:0]                   OUT_CHANNEL,
    output logic [PERIOD_BITS-1:0]          OUT_PERIOD,
    output logic                            OUT_TIMEOUT,
    output logic [CHANNELS-1:0]             OVERRUN,
    input  logic                            OVERRUN_CLEAR
);
    localparam logic [TIMEOUT_BITS-1:0] SIL_MAX   = TIMEOUT_BITS'(TIMEOUT_CYCLES);
    localparam logic [1:0]              DISC_INIT = 2'(DISCARD_COUNT);

    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_n;

    logic                    ce_q;
    logic [1:0]              disc     [CHANNELS];
    logic [TIMEOUT_BITS-1:0] sil      [CHANNELS];
    logic [PERIOD_BITS-1:0]  slot_val [CHANNELS];
    logic [CHANNELS-1:0]     slot_to, pend, cap, keep, inc, tmo, wr, gnt;
    logic [CW-1:0]           ptr, sel, idx;
    logic                    any, grant;

    // Round-robin pick of the first pending slot after the last granted one, plus output FSM next state
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = CW'((int'(ptr) + k) % CHANNELS);
            if (pend[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
        grant   = (state == EMPTY) || OUT_READY;
        state_n = grant ? (any ? FULL : EMPTY) : state;
    end

    // Per-channel capture, warm-up discard and silence-timeout decisions
    always_comb begin
        cap  = '0;
        keep = '0;
        inc  = '0;
        tmo  = '0;
        wr   = '0;
        gnt  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cap[c]  = CH_CE[c] & CH_CHANGE_FLAG[c];
            keep[c] = cap[c] & (disc[c] == 2'd0);
            inc[c]  = CH_CE[c] & ~CH_CHANGE_FLAG[c] & (disc[c] == 2'd0) & (sil[c] != SIL_MAX);
            tmo[c]  = inc[c] & (sil[c] == SIL_MAX - 1'b1);
            wr[c]   = keep[c] | tmo[c];
            gnt[c]  = grant & any & (sel == CW'(c));
        end
    end

    // Channel state: enables, discard/silence counters, slots and sticky overrun (set beats clear)
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            ce_q    <= 1'b0;
            CH_CE   <= '0;
            pend    <= '0;
            slot_to <= '0;
            OVERRUN <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                disc[c]     <= DISC_INIT;
                sil[c]      <= '0;
                slot_val[c] <= '0;
            end
        end else begin
            ce_q    <= CE;
            CH_CE   <= {CHANNELS{CE}};
            pend    <= wr | (pend & ~gnt);
            OVERRUN <= (wr & pend & ~gnt) | (OVERRUN & ~{CHANNELS{OVERRUN_CLEAR}});
            for (int c = 0; c < CHANNELS; c++) begin
                if (CE && !ce_q) disc[c] <= DISC_INIT;
                else if (cap[c] && disc[c] != 2'd0) disc[c] <= disc[c] - 2'd1;
                if (cap[c]) sil[c] <= '0;
                else if (inc[c]) sil[c] <= sil[c] + 1'b1;
                if (wr[c]) begin
                    slot_val[c] <= keep[c] ? CH_PERIOD[c*PERIOD_BITS +: PERIOD_BITS] : '0;
                    slot_to[c]  <= ~keep[c];
                end
            end
        end
    end

    // Output FSM state register
    always_ff @(posedge CLK_PARALLEL) begin
        state <= RESET ? EMPTY : state_n;
    end

    // Output word register and round-robin pointer, loaded on every grant that finds a pending slot
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            OUT_CHANNEL <= '0;
            OUT_PERIOD  <= '0;
            OUT_TIMEOUT <= 1'b0;
            ptr         <= '0;
        end else if (grant && any) begin
            OUT_CHANNEL <= sel;
            OUT_PERIOD  <= slot_val[sel];
            OUT_TIMEOUT <= slot_to[sel];
            ptr         <= sel;
        end
    end

    assign OUT_VALID = (state == FULL);
endmodule
